// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and widths for the SDRAM port arbiter
package sdram_arb_pkg;
  localparam int GRANTW = 3;
  localparam int TOW = 16;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: round-robin pick of the first set request at or after ptr
module rr_priority_select
  import sdram_arb_pkg::*;
#(
  parameter int PORTS = 5
) (
  input  logic [PORTS-1:0]  req,
  input  logic [GRANTW-1:0] ptr,
  output logic              valid,
  output logic [GRANTW-1:0] idx
);
  logic [PORTS-1:0] rot;
  logic [GRANTW-1:0] off;
  logic [GRANTW:0] sum;
  always_comb begin
    rot = PORTS'({req, req} >> ptr);
    off = '0;
    for (int j = PORTS - 1; j >= 0; j--) if (rot[j]) off = GRANTW'(j);
    sum = {1'b0, ptr} + {1'b0, off};
    valid = |req;
    idx = sum >= (GRANTW+1)'(PORTS) ? GRANTW'(sum - (GRANTW+1)'(PORTS)) : sum[GRANTW-1:0];
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM controller port with a
// slot-strobed launch, a hung-transaction watchdog and an abort counter.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int PORTS   = 5,
  parameter int ADDRW   = 22,
  parameter int DATAW   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slot_stb,
  input  logic [PORTS-1:0]       req,
  input  logic [PORTS-1:0]       we,
  input  logic [PORTS*ADDRW-1:0] a,
  input  logic [PORTS*DATAW-1:0] din,
  input  logic [PORTS*2-1:0]     be,
  output logic [PORTS-1:0]       ack,
  output logic [DATAW-1:0]       dout,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDRW-1:0]       mem_a,
  output logic [DATAW-1:0]       mem_din,
  output logic [1:0]             mem_be,
  input  logic                   mem_ack,
  input  logic [DATAW-1:0]       mem_dout,
  output logic [GRANTW-1:0]      grant_idx,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [TOW-1:0]         timeout_cnt
);
  state_t state_q;
  logic [GRANTW-1:0] ptr_q, ptr_d, grant_q, sel;
  logic [TOW-1:0] wcnt_q, tcnt_q;
  logic [PORTS-1:0] ack_q;
  logic [DATAW-1:0] dout_q, mem_din_q;
  logic [ADDRW-1:0] mem_a_q;
  logic [1:0] mem_be_q;
  logic mem_req_q, mem_we_q, terr_q, sel_valid, expire;
  rr_priority_select #(.PORTS(PORTS)) u_sel (
    .req(req),
    .ptr(ptr_q),
    .valid(sel_valid),
    .idx(sel)
  );
  assign ptr_d = grant_q == GRANTW'(PORTS - 1) ? '0 : grant_q + 1'b1;
  assign expire = wcnt_q == TOW'(TIMEOUT - 1);
  assign ack = ack_q;
  assign dout = dout_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_a = mem_a_q;
  assign mem_din = mem_din_q;
  assign mem_be = mem_be_q;
  assign grant_idx = grant_q;
  assign busy = state_q != IDLE;
  assign timeout_err = terr_q;
  assign timeout_cnt = tcnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      wcnt_q <= '0;
      tcnt_q <= '0;
      ack_q <= '0;
      dout_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_a_q <= '0;
      mem_din_q <= '0;
      mem_be_q <= '0;
      terr_q <= 1'b0;
    end else begin
      ack_q <= '0;
      terr_q <= 1'b0;
      case (state_q)
        IDLE: if (slot_stb && sel_valid) begin
          state_q <= WAIT;
          grant_q <= sel;
          wcnt_q <= '0;
          mem_req_q <= 1'b1;
          mem_we_q <= we[sel];
          mem_a_q <= a[sel*ADDRW +: ADDRW];
          mem_din_q <= din[sel*DATAW +: DATAW];
          mem_be_q <= be[sel*2 +: 2];
        end
        // a same-cycle mem_ack wins over the watchdog
        WAIT: if (mem_ack || expire) begin
          state_q <= DONE;
          mem_req_q <= 1'b0;
          ack_q <= PORTS'(1) << grant_q;
          dout_q <= mem_ack ? mem_dout : '0;
          terr_q <= !mem_ack;
          ptr_q <= ptr_d;
          if (!mem_ack && tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
        end else wcnt_q <= wcnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios with hand-computed expectations
module tb_sdram_port_arbiter;
  localparam int P = 5, AW = 22, DW = 16;
  logic clk = 1'b0, reset, slot_stb, mem_ack, mem_req, mem_we, busy, timeout_err;
  logic [P-1:0] req, we, ack;
  logic [P*AW-1:0] a;
  logic [P*DW-1:0] din;
  logic [P*2-1:0] be;
  logic [DW-1:0] dout, mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic [1:0] mem_be;
  logic [2:0] grant_idx;
  logic [15:0] timeout_cnt;
  int vec = 0, err = 0, multi = 0;
  always #5 clk = ~clk;
  sdram_port_arbiter #(.PORTS(P), .ADDRW(AW), .DATAW(DW), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .slot_stb(slot_stb), .req(req), .we(we), .a(a), .din(din), .be(be),
    .ack(ack), .dout(dout), .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_dout(mem_dout), .grant_idx(grant_idx), .busy(busy),
    .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
  );
  always @(negedge clk) if ($countones(ack) > 1) multi++;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task run_txn(input int dly, input logic [15:0] d, output logic [2:0] g, output logic [4:0] ak, output logic [15:0] dq);
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    g = grant_idx;
    repeat (dly - 1) tick;
    mem_ack = 1'b1;
    mem_dout = d;
    tick;
    mem_ack = 1'b0;
    ak = ack;
    dq = dout;
    tick;
  endtask

  task test_reset;
    reset = 1'b1; slot_stb = 1'b0; mem_ack = 1'b0; mem_dout = '0;
    req = '0; we = '0; a = '0; din = '0; be = '0;
    repeat (2) tick;
    vec++; if (mem_req !== 1'b0) begin err++; $display("FAIL rst_mem_req got %0h want 0", mem_req); end
    vec++; if (ack !== 5'b0) begin err++; $display("FAIL rst_ack got %b want 00000", ack); end
    vec++; if (grant_idx !== 3'd0) begin err++; $display("FAIL rst_grant got %0d want 0", grant_idx); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %0h want 0", busy); end
    vec++; if (timeout_cnt !== 16'd0) begin err++; $display("FAIL rst_tcnt got %0d want 0", timeout_cnt); end
    vec++; if (dout !== 16'd0 || timeout_err !== 1'b0) begin err++; $display("FAIL rst_dout_terr got %h/%0h want 0/0", dout, timeout_err); end
    reset = 1'b0;
    tick;
  endtask

  task test_single_read;
    req = 5'b00001;
    a[0 +: AW] = 22'h000100;
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    vec++; if (mem_req !== 1'b1) begin err++; $display("FAIL rd_mem_req got %0h want 1", mem_req); end
    vec++; if (mem_a !== 22'h000100) begin err++; $display("FAIL rd_mem_a got %h want 000100", mem_a); end
    vec++; if (mem_we !== 1'b0 || grant_idx !== 3'd0 || busy !== 1'b1) begin err++; $display("FAIL rd_grant got we=%0h g=%0d busy=%0h want 0/0/1", mem_we, grant_idx, busy); end
    repeat (3) tick;
    vec++; if (mem_req !== 1'b1 || ack !== 5'b0) begin err++; $display("FAIL rd_wait got req=%0h ack=%b want 1/00000", mem_req, ack); end
    mem_ack = 1'b1;
    mem_dout = 16'h1234;
    tick;
    mem_ack = 1'b0;
    vec++; if (ack !== 5'b00001) begin err++; $display("FAIL rd_ack got %b want 00001", ack); end
    vec++; if (dout !== 16'h1234 || mem_req !== 1'b0) begin err++; $display("FAIL rd_dout got %h req=%0h want 1234/0", dout, mem_req); end
    tick;
    vec++; if (ack !== 5'b0 || busy !== 1'b0) begin err++; $display("FAIL rd_pulse got ack=%b busy=%0h want 00000/0", ack, busy); end
    req = '0;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    vec++; if (ack !== 5'b0 || busy !== 1'b0) begin err++; $display("FAIL stray_ack got ack=%b busy=%0h want 00000/0", ack, busy); end
  endtask

  task test_round_robin;
    logic [2:0] g;
    logic [4:0] ak;
    logic [15:0] dq;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      run_txn(2, 16'h0100 + 16'(i), g, ak, dq);
      vec++; if (g !== 3'(i % 5)) begin err++; $display("FAIL rr_grant%0d got %0d want %0d", i, g, i % 5); end
      vec++; if (ak !== 5'(1 << (i % 5)) || dq !== 16'h0100 + 16'(i)) begin err++; $display("FAIL rr_ack%0d got %b/%h want %b/%h", i, ak, dq, 5'(1 << (i % 5)), 16'h0100 + 16'(i)); end
    end
    vec++; if (multi !== 0) begin err++; $display("FAIL rr_onehot got %0d multi-ack cycles want 0", multi); end
    req = '0;
  endtask

  task test_write;
    req = 5'b00100;
    we = 5'b00100;
    a[2*AW +: AW] = 22'h3ABCD;
    din[2*DW +: DW] = 16'hA55A;
    be[4 +: 2] = 2'b10;
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    vec++; if (mem_we !== 1'b1 || mem_din !== 16'hA55A || mem_be !== 2'b10) begin err++; $display("FAIL wr_fields got we=%0h din=%h be=%b want 1/a55a/10", mem_we, mem_din, mem_be); end
    vec++; if (grant_idx !== 3'd2 || busy !== 1'b1 || mem_a !== 22'h3ABCD) begin err++; $display("FAIL wr_grant got g=%0d busy=%0h a=%h want 2/1/3abcd", grant_idx, busy, mem_a); end
    din[2*DW +: DW] = 16'h0000;
    we = '0;
    tick;
    vec++; if (mem_din !== 16'hA55A || mem_we !== 1'b1) begin err++; $display("FAIL wr_stable got din=%h we=%0h want a55a/1", mem_din, mem_we); end
    mem_ack = 1'b1;
    mem_dout = 16'hBEEF;
    tick;
    mem_ack = 1'b0;
    vec++; if (ack !== 5'b00100 || busy !== 1'b1 || dout !== 16'hBEEF) begin err++; $display("FAIL wr_done got ack=%b busy=%0h dout=%h want 00100/1/beef", ack, busy, dout); end
    tick;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL wr_idle got busy=%0h want 0", busy); end
    req = '0;
  endtask

  task test_timeout;
    logic [2:0] g;
    logic [4:0] ak;
    logic [15:0] dq;
    req = 5'b11000;
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    vec++; if (grant_idx !== 3'd3) begin err++; $display("FAIL to_grant got %0d want 3", grant_idx); end
    repeat (254) tick;
    vec++; if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin err++; $display("FAIL to_early got req=%0h terr=%0h want 1/0", mem_req, timeout_err); end
    tick;
    vec++; if (mem_req !== 1'b0 || ack !== 5'b01000) begin err++; $display("FAIL to_abort got req=%0h ack=%b want 0/01000", mem_req, ack); end
    vec++; if (timeout_err !== 1'b1 || timeout_cnt !== 16'd1 || dout !== 16'd0) begin err++; $display("FAIL to_flags got terr=%0h cnt=%0d dout=%h want 1/1/0000", timeout_err, timeout_cnt, dout); end
    tick;
    vec++; if (timeout_err !== 1'b0 || ack !== 5'b0) begin err++; $display("FAIL to_pulse got terr=%0h ack=%b want 0/00000", timeout_err, ack); end
    run_txn(3, 16'h7777, g, ak, dq);
    vec++; if (g !== 3'd4 || ak !== 5'b10000) begin err++; $display("FAIL to_next got g=%0d ack=%b want 4/10000", g, ak); end
    req = '0;
  endtask

  task test_timeout_race;
    req = 5'b00010;
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    vec++; if (grant_idx !== 3'd1) begin err++; $display("FAIL race_grant got %0d want 1", grant_idx); end
    repeat (254) tick;
    mem_ack = 1'b1;
    mem_dout = 16'h5A5A;
    tick;
    mem_ack = 1'b0;
    vec++; if (ack !== 5'b00010 || dout !== 16'h5A5A) begin err++; $display("FAIL race_ack got ack=%b dout=%h want 00010/5a5a", ack, dout); end
    vec++; if (timeout_err !== 1'b0 || timeout_cnt !== 16'd1) begin err++; $display("FAIL race_flags got terr=%0h cnt=%0d want 0/1", timeout_err, timeout_cnt); end
    tick;
    req = '0;
  endtask

  task test_reset_mid;
    logic [2:0] g;
    logic [4:0] ak;
    logic [15:0] dq;
    req = 5'b01000;
    slot_stb = 1'b1;
    tick;
    slot_stb = 1'b0;
    vec++; if (grant_idx !== 3'd3) begin err++; $display("FAIL rm_grant got %0d want 3", grant_idx); end
    repeat (2) tick;
    reset = 1'b1;
    tick;
    vec++; if (mem_req !== 1'b0 || ack !== 5'b0 || grant_idx !== 3'd0 || busy !== 1'b0) begin err++; $display("FAIL rm_reset got req=%0h ack=%b g=%0d busy=%0h want 0/00000/0/0", mem_req, ack, grant_idx, busy); end
    reset = 1'b0;
    req = 5'b01001;
    tick;
    run_txn(2, 16'h0042, g, ak, dq);
    vec++; if (g !== 3'd0 || ak !== 5'b00001) begin err++; $display("FAIL rm_first got g=%0d ack=%b want 0/00001", g, ak); end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_write;
    test_timeout;
    test_timeout_race;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
